// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: bus widths, load_op bit indices
// and where the exception flags live inside the opaque pass-through payload.
package mem_stage_pkg;

  localparam int PASS_WD_DEF      = 128;
  localparam int ES_TO_MS_BUS_WD  = PASS_WD_DEF + 76;
  localparam int MS_TO_WS_BUS_WD  = PASS_WD_DEF + 70;
  localparam int MS_FWD_BUS_WD    = 39;

  // load_op is one-hot in this bit order
  localparam int LD_B  = 0;
  localparam int LD_H  = 1;
  localparam int LD_W  = 2;
  localparam int LD_BU = 3;
  localparam int LD_HU = 4;

  // exception flags occupy pass[EX_HI:EX_LO]
  localparam int EX_LO = 0;
  localparam int EX_HI = 7;

endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the byte/halfword addressed by addr[1:0] out of the read word and
// sign- or zero-extends it according to the one-hot load_op.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [4:0]  load_op,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    if (load_op[LD_B])       result = {{24{byte_sel[7]}}, byte_sel};
    else if (load_op[LD_BU]) result = {24'h0, byte_sel};
    else if (load_op[LD_H])  result = {{16{half_sel[15]}}, half_sel};
    else if (load_op[LD_HU]) result = {16'h0, half_sel};
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: holds one instruction, waits for its data-SRAM
// response, aligns load data and hands result/payload on to writeback.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int PASS_WD = PASS_WD_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 es_to_ms_valid,
  output logic                 ms_allowin,
  input  logic [PASS_WD+75:0]  es_to_ms_bus,
  input  logic                 es_req_pending,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  output logic                 ms_to_ws_valid,
  input  logic                 ws_allowin,
  output logic [PASS_WD+69:0]  ms_to_ws_bus,
  input  logic                 ws_block,
  output logic [38:0]          ms_fwd_bus,
  output logic                 ms_ex
);

  logic                ms_valid;
  logic                buf_valid;
  logic [31:0]         buf_rdata;
  logic [1:0]          discard_cnt;
  logic [PASS_WD+75:0] bus_r;

  logic [PASS_WD-1:0]  pass;
  logic                mem_req;
  logic [4:0]          load_op;
  logic                gr_we;
  logic [4:0]          dest;
  logic [31:0]         result;
  logic [31:0]         pc;

  assign {pass, mem_req, load_op, gr_we, dest, result, pc} = bus_r;

  logic        own_ok;
  logic        ms_ready_go;
  logic        ms_leave;
  logic        is_load;
  logic [31:0] rdata_mux;
  logic [31:0] load_result;
  logic [31:0] final_result;

  // a response only belongs to the live instruction once all stale ones drained
  assign own_ok      = data_sram_data_ok && (discard_cnt == 2'd0);
  assign ms_ready_go = !mem_req || buf_valid || own_ok;
  assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !ws_block;
  assign ms_leave    = ms_valid && ms_ready_go && ws_allowin;
  assign is_load     = |load_op;
  assign rdata_mux   = buf_valid ? buf_rdata : data_sram_rdata;

  mem_load_align u_align (
    .rdata   (rdata_mux),
    .addr    (result[1:0]),
    .load_op (load_op),
    .result  (load_result)
  );

  assign final_result = is_load ? load_result : result;

  assign ms_to_ws_bus = {pass, gr_we, dest, final_result, pc};
  assign ms_fwd_bus   = {ms_valid && gr_we, ms_valid && is_load && !ms_ready_go,
                         dest, final_result};
  assign ms_ex        = ms_valid && (|pass[EX_HI:EX_LO]);

  // discard accounting: flushed requests still owe a response
  logic [1:0] cnt_inc;
  logic       cnt_dec;
  logic [2:0] cnt_sum;

  always_comb begin
    cnt_inc = 2'd0;
    if (ws_block)
      cnt_inc = 2'({1'b0, ms_valid && mem_req && !buf_valid && !own_ok})
              + 2'({1'b0, es_req_pending});
    cnt_dec = data_sram_data_ok && (discard_cnt != 2'd0);
    cnt_sum = 3'(discard_cnt) + 3'(cnt_inc) - 3'(cnt_dec);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid    <= 1'b0;
      buf_valid   <= 1'b0;
      buf_rdata   <= 32'h0;
      discard_cnt <= 2'd0;
      bus_r       <= '0;
    end else begin
      assert (cnt_sum <= 3'd3);
      discard_cnt <= (cnt_sum > 3'd3) ? 2'd3 : cnt_sum[1:0];

      if (ws_block)        ms_valid <= 1'b0;
      else if (ms_allowin) ms_valid <= es_to_ms_valid;

      if (es_to_ms_valid && ms_allowin) bus_r <= es_to_ms_bus;

      if (ws_block || ms_leave) begin
        buf_valid <= 1'b0;
      end else if (ms_valid && mem_req && !buf_valid && own_ok && !ws_allowin) begin
        buf_valid <= 1'b1;
        buf_rdata <= data_sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed checks of mem_stage: load alignment, response buffering,
// discard after flush, and back-to-back ALU flow.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int PW  = PASS_WD_DEF;
  localparam int ESW = PW + 76;
  localparam int WSW = PW + 70;

  logic           clk = 1'b0;
  logic           reset;
  logic           es_to_ms_valid;
  logic           ms_allowin;
  logic [ESW-1:0] es_to_ms_bus;
  logic           es_req_pending;
  logic           data_sram_data_ok;
  logic [31:0]    data_sram_rdata;
  logic           ms_to_ws_valid;
  logic           ws_allowin;
  logic [WSW-1:0] ms_to_ws_bus;
  logic           ws_block;
  logic [38:0]    ms_fwd_bus;
  logic           ms_ex;

  int total = 0;
  int bad   = 0;

  mem_stage #(.PASS_WD(PW)) dut (
    .clk               (clk),
    .reset             (reset),
    .es_to_ms_valid    (es_to_ms_valid),
    .ms_allowin        (ms_allowin),
    .es_to_ms_bus      (es_to_ms_bus),
    .es_req_pending    (es_req_pending),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ws_block          (ws_block),
    .ms_fwd_bus        (ms_fwd_bus),
    .ms_ex             (ms_ex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [ESW-1:0] mk(input logic [PW-1:0] pass, input logic mreq,
                                        input logic [4:0] op, input logic [4:0] dest,
                                        input logic [31:0] res);
    return {pass, mreq, op, 1'b1, dest, res, 32'h1c00_0040};
  endfunction

  task automatic issue(input logic [ESW-1:0] bus);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = bus;
    cyc();
    es_to_ms_valid = 1'b0;
  endtask

  // issue a load, wait n cycles without a response, then respond and check
  task automatic do_load(input string tag, input int op_bit, input logic [31:0] addr,
                         input logic [31:0] rdata, input int n, input logic [31:0] exp);
    logic [4:0] op;
    op = 5'b0;
    op[op_bit] = 1'b1;
    issue(mk('0, 1'b1, op, 5'd5, addr));
    for (int i = 0; i < n; i++) begin
      settle();
      chk({tag, "_wait"}, {63'b0, ms_to_ws_valid}, 64'd0);
      chk({tag, "_dwait"}, {63'b0, ms_fwd_bus[37]}, 64'd1);
      cyc();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    settle();
    chk({tag, "_vld"}, {63'b0, ms_to_ws_valid}, 64'd1);
    chk({tag, "_res"}, {32'b0, ms_to_ws_bus[63:32]}, {32'b0, exp});
    cyc();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    settle();
    chk({tag, "_gone"}, {63'b0, ms_to_ws_valid}, 64'd0);
  endtask

  initial begin
    logic [PW-1:0] exc;
    exc = '0;
    exc[EX_LO] = 1'b1;

    reset = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    es_req_pending = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0;
    ws_allowin = 1'b1;
    ws_block = 1'b0;
    cyc();
    cyc();
    settle();
    chk("rst_vld",    {63'b0, ms_to_ws_valid}, 64'd0);
    chk("rst_allow",  {63'b0, ms_allowin}, 64'd1);
    chk("rst_ex",     {63'b0, ms_ex}, 64'd0);
    chk("rst_fwdvld", {63'b0, ms_fwd_bus[38]}, 64'd0);
    reset = 1'b0;
    cyc();

    do_load("ldb",  LD_B,  32'h1003, 32'h80FF_1234, 2, 32'hFFFF_FF80);
    do_load("ldbu", LD_BU, 32'h1003, 32'h80FF_1234, 2, 32'h0000_0080);
    do_load("ldh",  LD_H,  32'h2002, 32'h8001_0000, 1, 32'hFFFF_8001);
    do_load("ldhu", LD_HU, 32'h2002, 32'h8001_0000, 0, 32'h0000_8001);
    do_load("ldb1", LD_B,  32'h3001, 32'h0000_7F00, 0, 32'h0000_007F);

    // response arrives while ws is stalled: buffered and delivered later
    ws_allowin = 1'b0;
    issue(mk('0, 1'b1, 5'b00100, 5'd7, 32'h4000));
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hDEAD_BEEF;
    settle();
    chk("buf_vld0",  {63'b0, ms_to_ws_valid}, 64'd1);
    chk("buf_allow", {63'b0, ms_allowin}, 64'd0);
    cyc();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("buf_hold", {63'b0, ms_to_ws_valid}, 64'd1);
      chk("buf_data", {32'b0, ms_to_ws_bus[63:32]}, 64'hDEAD_BEEF);
      cyc();
    end
    ws_allowin = 1'b1;
    settle();
    chk("buf_rel",   {63'b0, ms_to_ws_valid}, 64'd1);
    chk("buf_rdat",  {32'b0, ms_to_ws_bus[63:32]}, 64'hDEAD_BEEF);
    chk("buf_alw1",  {63'b0, ms_allowin}, 64'd1);
    cyc();
    settle();
    chk("buf_gone",  {63'b0, ms_to_ws_valid}, 64'd0);

    // flush with a waiting load and a pending es request: two stale responses
    issue(mk('0, 1'b1, 5'b00100, 5'd8, 32'h5000));
    ws_block = 1'b1;
    es_req_pending = 1'b1;
    settle();
    chk("fl_vld", {63'b0, ms_to_ws_valid}, 64'd0);
    cyc();
    ws_block = 1'b0;
    es_req_pending = 1'b0;
    issue(mk('0, 1'b1, 5'b00100, 5'd9, 32'h6000));
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1111_1111;
    settle();
    chk("disc1", {63'b0, ms_to_ws_valid}, 64'd0);
    cyc();
    data_sram_rdata = 32'h2222_2222;
    settle();
    chk("disc2", {63'b0, ms_to_ws_valid}, 64'd0);
    cyc();
    data_sram_rdata = 32'h3333_3333;
    settle();
    chk("disc3_vld", {63'b0, ms_to_ws_valid}, 64'd1);
    chk("disc3_res", {32'b0, ms_to_ws_bus[63:32]}, 64'h3333_3333);
    cyc();
    data_sram_data_ok = 1'b0;

    // flush in the same cycle as the load's own response
    issue(mk('0, 1'b1, 5'b00100, 5'd10, 32'h7000));
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h5555_5555;
    ws_block = 1'b1;
    settle();
    chk("sf_vld", {63'b0, ms_to_ws_valid}, 64'd0);
    cyc();
    data_sram_data_ok = 1'b0;
    ws_block = 1'b0;
    settle();
    chk("sf_drop",  {63'b0, ms_to_ws_valid}, 64'd0);
    chk("sf_allow", {63'b0, ms_allowin}, 64'd1);
    issue(mk('0, 1'b1, 5'b00100, 5'd11, 32'h7004));
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h4444_4444;
    settle();
    chk("sf_next_vld", {63'b0, ms_to_ws_valid}, 64'd1);
    chk("sf_next_res", {32'b0, ms_to_ws_bus[63:32]}, 64'h4444_4444);
    cyc();
    data_sram_data_ok = 1'b0;

    // flush beats accept
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk('0, 1'b0, 5'b0, 5'd3, 32'hBAD0);
    ws_block = 1'b1;
    cyc();
    es_to_ms_valid = 1'b0;
    ws_block = 1'b0;
    settle();
    chk("fl_prio", {63'b0, ms_to_ws_valid}, 64'd0);
    cyc();

    // back-to-back ALU ops
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk('0, 1'b0, 5'b0, 5'd1, 32'h0000_000A);
    cyc();
    es_to_ms_bus = mk(exc, 1'b0, 5'b0, 5'd2, 32'h0000_000B);
    settle();
    chk("alu_a_vld", {63'b0, ms_to_ws_valid}, 64'd1);
    chk("alu_a_res", {32'b0, ms_to_ws_bus[63:32]}, 64'hA);
    chk("alu_a_ex",  {63'b0, ms_ex}, 64'd0);
    chk("alu_a_fwd", {25'b0, ms_fwd_bus}, {25'b0, 1'b1, 1'b0, 5'd1, 32'hA});
    chk("alu_a_pc",  {32'b0, ms_to_ws_bus[31:0]}, 64'h1c00_0040);
    cyc();
    es_to_ms_bus = mk('0, 1'b0, 5'b0, 5'd3, 32'h0000_000C);
    settle();
    chk("alu_b_res", {32'b0, ms_to_ws_bus[63:32]}, 64'hB);
    chk("alu_b_ex",  {63'b0, ms_ex}, 64'd1);
    cyc();
    es_to_ms_valid = 1'b0;
    settle();
    chk("alu_c_res", {32'b0, ms_to_ws_bus[63:32]}, 64'hC);
    chk("alu_c_ex",  {63'b0, ms_ex}, 64'd0);
    chk("alu_c_dst", {59'b0, ms_to_ws_bus[68:64]}, 64'd3);
    cyc();
    settle();
    chk("alu_done",  {63'b0, ms_to_ws_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage LoongArch pipeline, between the execute stage (es) and the writeback stage (ws).
- Accepts instructions from es and waits for the data-SRAM response of loads/stores that es already issued (addr_ok seen in es).
- Aligns and extends load data, then forwards result, destination, CSR/TLB/exception payload to ws.
- Supplies a forwarding/blocking view to decode and an exception-present flag to es so younger stores are suppressed.

Parameters:
- PASS_WD, 128, width of the opaque payload (CSR, TLB, exception fields) carried unchanged es to ws.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- es_to_ms_valid  in  1  es holds a valid instruction
- ms_allowin  out  1  ms can accept this cycle
- es_to_ms_bus  in  PASS_WD+76  {pass, mem_req, load_op[4:0] one-hot b/h/w/bu/hu, gr_we, dest[4:0], result[31:0], pc[31:0]}
- es_req_pending  in  1  es holds an instruction whose request got addr_ok but has not moved to ms
- data_sram_data_ok  in  1  response handshake
- data_sram_rdata  in  32  response data
- ms_to_ws_valid  out  1  valid to ws
- ws_allowin  in  1  ws can accept
- ms_to_ws_bus  out  PASS_WD+70  {pass, gr_we, dest[4:0], final_result[31:0], pc[31:0]}
- ws_block  in  1  exception/ertn/refetch flush from ws
- ms_fwd_bus  out  39  {ms_valid&gr_we, data_wait, dest[4:0], final_result[31:0]}
- ms_ex  out  1  ms_valid and any exception bit in pass set (bit positions in shared package)

Behaviour:
- Reset: ms_valid=0, buf_valid=0, discard_cnt=0, bus register=0. All outputs derive from these, so ms_to_ws_valid=0, ms_fwd_bus valid bit=0, ms_ex=0.
- Latency: 1 cycle minimum (bus registered on es_to_ms_valid && ms_allowin). Loads/stores take extra cycles until their data_ok.
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- ms_to_ws_valid = ms_valid && ms_ready_go && !ws_block.
- ms_ready_go = !mem_req || buf_valid || (data_sram_data_ok && discard_cnt==0). An instruction carrying an exception still waits for its own data_ok if mem_req=1.
- Response buffer: data_ok with discard_cnt==0 while ms_valid && mem_req && !(ws_allowin) sets buf_valid and captures rdata. buf_valid clears when the instruction leaves ms or on flush.
- Load extraction uses result[1:0]:
  - b/bu select byte result[1:0]*8.
  - h/hu select halfword result[1]*16.
  - w uses the full word.
  - Sign-extend for b/h, zero-extend for bu/hu.
  - Non-load: final_result = result.
- Discard counter (2 bit):
  - On ws_block, ms_valid <= 0 and buf_valid <= 0.
  - discard_cnt increments by (ms_valid && mem_req && !buf_valid && !data_ok_this_cycle) + es_req_pending.
  - Any data_ok while discard_cnt>0 decrements it and is ignored; it never completes a live instruction.
  - Increment and decrement in the same cycle net out.
  - Counter saturates at 3 (assertion: never exceeded).
- ms_fwd_bus data_wait = ms_valid && load && !ms_ready_go; decode stalls on a matching dest.
- Flush has priority over accept: es_to_ms_valid in a ws_block cycle is not latched as valid.
- Reset mid-operation clears discard_cnt; outstanding responses are the memory side's reset responsibility.

Decomposition:
- Shared package (mycpu.h defines):
  - bus widths ES_TO_MS_BUS_WD, MS_TO_WS_BUS_WD, MS_FWD_BUS_WD
  - load_op bit indices
  - exception-bit positions inside pass
- One natural sub-module: mem_load_align (combinational: rdata, addr[1:0], load_op -> 32-bit result).

Test Plan:
- ld.b, result=0x1003, rdata=0x80FF_1234, data_ok after 2 cycles -> final_result=0xFFFF_FF80 to ws the same cycle as data_ok; ld.bu -> 0x0000_0080.
- ld.h at addr 0x...2, rdata=0x8001_0000 -> 0xFFFF_8001; ld.hu -> 0x0000_8001.
- data_ok arrives while ws_allowin=0 for 3 cycles -> buf_valid=1, data held, delivered once ws_allowin=1, no second data_ok needed.
- ws_block while ms load waits and es_req_pending=1 -> discard_cnt=2, next two data_ok ignored, following load completes with the third data_ok.
- ws_block in the same cycle as the current load's data_ok -> discard_cnt stays 0, instruction dropped, no ms_to_ws_valid.
- ALU op (mem_req=0) back-to-back with ws_allowin=1 -> one instruction per cycle, ms_ex=1 only for an entry with an exception bit set.
